// File: rtl/output_buffer_arbiter.sv
// rtl/output_buffer_arbiter.sv - packet-granular round-robin arbiter feeding one output-buffer AXIS write port
module output_buffer_arbiter #(
  parameter int C_NUM_INPUTS          = 4,
  parameter int C_SEL_WIDTH           = 2,
  parameter int C_AXIS_DATA_WIDTH     = 256,
  parameter int C_PACKET_LENGTH_WIDTH = 14,
  parameter int C_INPORT_WIDTH        = 3,
  parameter int C_OUTPORT_WIDTH       = 8
) (
  input  logic                                              axi_aclk,
  input  logic                                              axi_resetn,
  input  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH/8-1:0]       s_axis_tkeep,
  input  logic [C_NUM_INPUTS*C_PACKET_LENGTH_WIDTH-1:0]     s_axis_tuser_packet_length,
  input  logic [C_NUM_INPUTS*C_INPORT_WIDTH-1:0]            s_axis_tuser_in_port,
  input  logic [C_NUM_INPUTS*C_OUTPORT_WIDTH-1:0]           s_axis_tuser_out_port,
  input  logic [C_NUM_INPUTS-1:0]                           s_axis_tvalid,
  input  logic [C_NUM_INPUTS-1:0]                           s_axis_tlast,
  output logic [C_NUM_INPUTS-1:0]                           s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]                    m_axis_tkeep,
  output logic [C_PACKET_LENGTH_WIDTH-1:0]                  m_axis_tuser_packet_length,
  output logic [C_INPORT_WIDTH-1:0]                         m_axis_tuser_in_port,
  output logic [C_OUTPORT_WIDTH-1:0]                        m_axis_tuser_out_port,
  output logic                                              m_axis_tvalid,
  input  logic                                              m_axis_tready,
  output logic                                              m_axis_tlast,
  output logic [C_SEL_WIDTH-1:0]                            grant,
  output logic [31:0]                                       pkt_count
);

  localparam int KW = C_AXIS_DATA_WIDTH / 8;

  typedef enum logic {IDLE, PASS} state_t;

  state_t                   state_q, state_d;
  logic [C_SEL_WIDTH-1:0]   grant_q, grant_d;
  logic [C_SEL_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [31:0]              pkt_count_q, pkt_count_d;

  logic                     rr_found;
  logic [C_SEL_WIDTH-1:0]   rr_idx;
  logic [C_SEL_WIDTH-1:0]   rr_cand;

  logic [C_AXIS_DATA_WIDTH-1:0]     tdata_arr [C_NUM_INPUTS];
  logic [KW-1:0]                    tkeep_arr [C_NUM_INPUTS];
  logic [C_PACKET_LENGTH_WIDTH-1:0] len_arr   [C_NUM_INPUTS];
  logic [C_INPORT_WIDTH-1:0]        inp_arr   [C_NUM_INPUTS];
  logic [C_OUTPORT_WIDTH-1:0]       outp_arr  [C_NUM_INPUTS];

  for (genvar i = 0; i < C_NUM_INPUTS; i++) begin : g_unpack
    assign tdata_arr[i] = s_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
    assign tkeep_arr[i] = s_axis_tkeep[i*KW +: KW];
    assign len_arr[i]   = s_axis_tuser_packet_length[i*C_PACKET_LENGTH_WIDTH +: C_PACKET_LENGTH_WIDTH];
    assign inp_arr[i]   = s_axis_tuser_in_port[i*C_INPORT_WIDTH +: C_INPORT_WIDTH];
    assign outp_arr[i]  = s_axis_tuser_out_port[i*C_OUTPORT_WIDTH +: C_OUTPORT_WIDTH];
  end

  // Search starts just after the last served input so every requester gets a turn.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int k = 1; k <= C_NUM_INPUTS; k++) begin
      rr_cand = C_SEL_WIDTH'((int'(last_grant_q) + k) % C_NUM_INPUTS);
      if (!rr_found && s_axis_tvalid[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  always_comb begin
    m_axis_tdata               = tdata_arr[grant_q];
    m_axis_tkeep               = tkeep_arr[grant_q];
    m_axis_tuser_packet_length = len_arr[grant_q];
    m_axis_tuser_in_port       = inp_arr[grant_q];
    m_axis_tuser_out_port      = outp_arr[grant_q];
    m_axis_tlast               = s_axis_tlast[grant_q];
    m_axis_tvalid              = 1'b0;
    s_axis_tready              = '0;
    if (state_q == PASS) begin
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pkt_count_d  = pkt_count_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_idx;
          state_d = PASS;
        end
      end
      PASS: begin
        // Grant is only released on the tlast handshake; a stalled source just waits.
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          last_grant_d = grant_q;
          pkt_count_d  = pkt_count_q + 32'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= C_SEL_WIDTH'(C_NUM_INPUTS - 1);
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign grant     = grant_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_output_buffer_arbiter.sv
// tb/tb_output_buffer_arbiter.sv - directed scoreboard bench for output_buffer_arbiter
module tb_output_buffer_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int LW = 14;
  localparam int IW = 3;
  localparam int OW = 8;
  localparam int SW = 2;

  typedef struct packed {
    logic [31:0]   data;
    logic          last;
    logic [IW-1:0] inport;
    logic [LW-1:0] len;
    logic [OW-1:0] outport;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [N*DW-1:0]   s_tdata;
  logic [N*KW-1:0]   s_tkeep;
  logic [N*LW-1:0]   s_len;
  logic [N*IW-1:0]   s_inp;
  logic [N*OW-1:0]   s_outp;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [LW-1:0]     m_len;
  logic [IW-1:0]     m_in_port;
  logic [OW-1:0]     m_out_port;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic [SW-1:0]     grant;
  logic [31:0]       pkt_count;

  output_buffer_arbiter #(
    .C_NUM_INPUTS(N), .C_SEL_WIDTH(SW), .C_AXIS_DATA_WIDTH(DW),
    .C_PACKET_LENGTH_WIDTH(LW), .C_INPORT_WIDTH(IW), .C_OUTPORT_WIDTH(OW)
  ) dut (
    .axi_aclk(clk), .axi_resetn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tuser_packet_length(s_len), .s_axis_tuser_in_port(s_inp),
    .s_axis_tuser_out_port(s_outp), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tuser_packet_length(m_len), .m_axis_tuser_in_port(m_in_port),
    .m_axis_tuser_out_port(m_out_port), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .grant(grant), .pkt_count(pkt_count)
  );

  beat_t    src_q [N][$];
  beat_t    expq [$];
  int       n_assert = 0;
  int       n_fail = 0;
  int       cyc = 0;
  int       last_end_cyc = -1;
  bit       in_pkt = 1'b0;
  bit       gap_en = 1'b0;
  logic [N-1:0] ready_snap;
  logic [N-1:0] hs;
  logic [6:0]   bp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_out();
    beat_t o;
    o.data    = m_tdata[31:0];
    o.last    = m_tlast;
    o.inport  = m_in_port;
    o.len     = m_len;
    o.outport = m_out_port;
    return 64'(o);
  endfunction

  task automatic drive_inputs();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        s_tdata[i*DW +: DW] = DW'(b.data);
        s_tkeep[i*KW +: KW] = '1;
        s_len[i*LW +: LW]   = b.len;
        s_inp[i*IW +: IW]   = b.inport;
        s_outp[i*OW +: OW]  = b.outport;
        s_tlast[i]          = b.last;
        s_tvalid[i]         = 1'b1;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
      end
    end
  endtask

  task automatic add_pkt(input int src, input int nb, input logic [31:0] base,
                         input logic [LW-1:0] len, input bit to_src, input bit to_exp);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.data    = base + 32'(k);
      b.last    = (k == nb - 1);
      b.inport  = IW'(src);
      b.len     = len;
      b.outport = 8'h01 << src;
      if (to_src) src_q[src].push_back(b);
      if (to_exp) expq.push_back(b);
    end
  endtask

  task automatic cycle();
    beat_t e;
    beat_t d;
    @(negedge clk);
    cyc++;
    ready_snap = s_tready;
    if (m_tvalid && m_tready) begin
      if (expq.size() == 0) begin
        check("extra_beat", 64'(expq.size()), 64'd1);
      end else begin
        e = expq.pop_front();
        check("beat", pack_out(), 64'(e));
      end
      if (!in_pkt) begin
        if (gap_en && last_end_cyc >= 0) check("bubble", 64'(cyc - last_end_cyc), 64'd2);
        in_pkt = 1'b1;
      end
      if (m_tlast) begin
        in_pkt = 1'b0;
        last_end_cyc = cyc;
      end
    end
    hs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && src_q[i].size() > 0) d = src_q[i].pop_front();
    end
    drive_inputs();
  endtask

  task automatic run_until_left(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (expq.size() > n && k < budget) begin
      cycle();
      k++;
    end
    check(tag, 64'(expq.size()), 64'(n));
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) src_q[i].delete();
    expq.delete();
    in_pkt = 1'b0;
    last_end_cyc = -1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    clear_all();
    drive_inputs();
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; m_tready = 1'b1;
    s_tdata = '0; s_tkeep = '0; s_len = '0; s_inp = '0; s_outp = '0;
    s_tlast = '0; s_tvalid = '1;

    // reset with every input requesting
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    @(posedge clk); #1;
    s_tvalid = '0;
    rstn = 1'b1;

    // single requester on input 2
    add_pkt(2, 3, 32'hA1, 14'd96, 1, 1);
    drive_inputs();
    cycle();
    check("t2_ready_idle", 64'(ready_snap), 64'd0);
    cycle();
    check("t2_ready_pass", 64'(ready_snap), 64'h4);
    run_until_left(0, 50, "t2_drain");
    check("t2_grant", 64'(grant), 64'd2);
    check("t2_pkt_count", 64'(pkt_count), 64'd1);

    // fairness: all inputs offering 2-beat packets
    apply_reset();
    gap_en = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < N; s++)
        add_pkt(s, 2, 32'h1000 * (s + 1) + 32'h10 * p, 14'd64, 1, 0);
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < N; s++)
        add_pkt(s, 2, 32'h1000 * (s + 1) + 32'h10 * p, 14'd64, 0, 1);
    drive_inputs();
    run_until_left(4, 100, "t3_six_pkts");
    check("t3_pkt_count6", 64'(pkt_count), 64'd6);
    run_until_left(0, 100, "t3_drain");
    check("t3_pkt_count8", 64'(pkt_count), 64'd8);
    gap_en = 1'b0;

    // back-pressure on input 0
    apply_reset();
    add_pkt(0, 4, 32'hB0, 14'd128, 1, 1);
    drive_inputs();
    cycle();
    bp = 7'b1101001;
    for (int k = 0; k < 7; k++) begin
      m_tready = bp[k];
      cycle();
      check("t4_mirror", 64'(ready_snap), 64'({3'b000, bp[k]}));
    end
    m_tready = 1'b1;
    check("t4_beats_left", 64'(expq.size()), 64'd0);
    check("t4_pkt_count", 64'(pkt_count), 64'd1);

    // single-beat packets on inputs 1 and 3 after reset (last_grant = 3)
    apply_reset();
    gap_en = 1'b1;
    add_pkt(1, 1, 32'hC1, 14'd32, 1, 1);
    add_pkt(3, 1, 32'hC3, 14'd32, 1, 1);
    drive_inputs();
    run_until_left(0, 30, "t5_drain");
    check("t5_pkt_count", 64'(pkt_count), 64'd2);
    check("t5_grant", 64'(grant), 64'd3);
    gap_en = 1'b0;

    // reset asserted on beat 2 of a 5-beat packet from input 3
    apply_reset();
    add_pkt(3, 5, 32'hD0, 14'd160, 1, 1);
    drive_inputs();
    cycle();
    cycle();
    check("t6_pre_tvalid", 64'(m_tvalid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_tvalid", 64'(m_tvalid), 64'd0);
    check("t6_tready", 64'(s_tready), 64'd0);
    check("t6_partial", 64'(expq.size()), 64'd4);
    clear_all();
    add_pkt(0, 2, 32'hE0, 14'd64, 1, 1);
    add_pkt(3, 2, 32'hE3, 14'd64, 1, 1);
    drive_inputs();
    @(posedge clk); #1;
    rstn = 1'b1;
    cycle();
    check("t6_grant", 64'(grant), 64'd0);
    run_until_left(0, 40, "t6_drain");
    check("t6_pkt_count", 64'(pkt_count), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
